// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// uart_tx -- 8-bit asynchronous serial transmitter (8N1, LSB first).
//
// Drains a dual-clock FIFO one byte per frame and drives the board TX pin.
// The FIFO read request is generated outside as
//   uart_en = (rdusedw != 0) && !send_sta_flg
// and this block starts a frame on the rising edge of uart_en. Raising the
// busy flag in that same edge makes uart_en drop after one cycle, so exactly
// one word is read per frame.
//
// Optional feature: define UART_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (11-bit frame).
//
// Parameters:
//   CLK_FREQ   sysclk_12 frequency in Hz
//   BAUD_RATE  line bit rate
//   BAUD_DIV   clocks per bit (integer truncation); must be >= 2
//
// Ports:
//   sysclk_12     in   sole clock, rising edge
//   i_rest        in   synchronous active-high reset; aborts any frame
//   paralle_data  in   FIFO q, valid one clock after the read edge
//   rdempty       in   FIFO read-side empty flag
//   uart_en       in   FIFO read request; its rising edge starts a frame
//   tx_data       out  serial line, idle high (registered)
//   send_sta_flg  out  busy flag, high for the whole frame (registered)
//
// Handshake: a request is accepted only in IDLE, on a clock where uart_en=1,
// uart_en was 0 on the previous clock, and rdempty=0. Acceptance raises
// send_sta_flg immediately; the byte is latched one clock later (LOAD), when
// the non-show-ahead FIFO has put it on paralle_data. Further edges on
// uart_en while busy are ignored.
//
// The FSM state is held in the internal signal 'state' (type state_t).

module uart_tx #(
  parameter int CLK_FREQ  = 12000000,
  parameter int BAUD_RATE = 115200,
  parameter int BAUD_DIV  = CLK_FREQ / BAUD_RATE
) (
  input  logic       sysclk_12,
  input  logic       i_rest,
  input  logic [7:0] paralle_data,
  input  logic       rdempty,
  input  logic       uart_en,
  output logic       tx_data,
  output logic       send_sta_flg
);

  localparam int CW = $clog2(BAUD_DIV);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd5
  } state_t;
`endif

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] baud_nxt;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_nxt;
  logic [7:0]    data_reg;
  logic [7:0]    data_nxt;
  logic          en_d;
  logic          tx_nxt;
  logic          busy_nxt;
  logic          baud_last;

  assign baud_last = (baud_cnt == CW'(BAUD_DIV - 1));

  // Next-state and registered-output logic. tx_nxt is the level the line
  // takes after the coming edge, so every bit boundary loads the next level
  // in the same edge that changes state or bit index.
  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    data_nxt    = data_reg;
    tx_nxt      = tx_data;
    busy_nxt    = send_sta_flg;
    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (uart_en && !en_d && !rdempty) begin
          state_nxt = S_LOAD;
          busy_nxt  = 1'b1;
        end
      end
      S_LOAD: begin
        // FIFO word is valid now, one clock after the read edge.
        data_nxt  = paralle_data;
        tx_nxt    = 1'b0;
        state_nxt = S_START;
      end
      S_START: begin
        if (baud_last) begin
          state_nxt   = S_DATA;
          bit_idx_nxt = 3'd0;
          tx_nxt      = data_reg[0];
        end
      end
      S_DATA: begin
        if (baud_last) begin
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_nxt = S_PARITY;
            tx_nxt    = ^data_reg;
`else
            state_nxt = S_STOP;
            tx_nxt    = 1'b1;
`endif
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            tx_nxt      = data_reg[bit_idx + 3'd1];
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          state_nxt = S_STOP;
          tx_nxt    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_last) begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Baud counter restarts on every state change, so each bit period is
  // exactly BAUD_DIV clocks measured from the edge that entered it.
  always_comb begin
    baud_nxt = baud_cnt + CW'(1);
    if ((state_nxt != state) || (state == S_IDLE) || baud_last) begin
      baud_nxt = '0;
    end
  end

  always_ff @(posedge sysclk_12) begin
    if (i_rest) begin
      state        <= S_IDLE;
      baud_cnt     <= '0;
      bit_idx      <= 3'd0;
      data_reg     <= 8'd0;
      en_d         <= 1'b0;
      tx_data      <= 1'b1;
      send_sta_flg <= 1'b0;
    end else begin
      state        <= state_nxt;
      baud_cnt     <= baud_nxt;
      bit_idx      <= bit_idx_nxt;
      data_reg     <= data_nxt;
      en_d         <= uart_en;
      tx_data      <= tx_nxt;
      send_sta_flg <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
`timescale 1ns/1ps
// tb_uart_tx -- self-checking bench for uart_tx.
// Stimulus drives a modelled FIFO (or a manual request line); expected bytes
// go into exp_q when issued, and a monitor pops one per observed frame and
// checks the line against a bit-level frame built from the byte.

module tb_uart_tx;

  localparam int B = 12000000 / 115200;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  // ---------------- clock / reset ----------------
  logic       sysclk_12 = 1'b0;
  logic       i_rest    = 1'b1;
  logic [7:0] paralle_data = 8'd0;
  logic       rdempty   = 1'b1;
  logic       uart_en   = 1'b0;
  logic       tx_data;
  logic       send_sta_flg;

  always #5 sysclk_12 = ~sysclk_12;

  uart_tx dut (
    .sysclk_12    (sysclk_12),
    .i_rest       (i_rest),
    .paralle_data (paralle_data),
    .rdempty      (rdempty),
    .uart_en      (uart_en),
    .tx_data      (tx_data),
    .send_sta_flg (send_sta_flg)
  );

  // ---------------- stimulus state ----------------
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic       fifo_mode = 1'b0;
  logic       man_en    = 1'b0;
  logic       man_empty = 1'b0;
  logic [7:0] man_data  = 8'd0;
  logic       mon_en    = 1'b1;
  logic       mon_busy  = 1'b0;
  int         rd_pulses = 0;
  int         cyc       = 0;
  int         last_end  = -1;
  int         last_gap  = -1;
  int         checks    = 0;
  int         passes    = 0;

  always @(posedge sysclk_12) cyc <= cyc + 1;

  // FIFO read side: a read at edge k presents its word after edge k.
  always @(posedge sysclk_12) begin
    if (!fifo_mode) begin
      paralle_data <= man_data;
    end else if (uart_en === 1'b1 && fifo_q.size() != 0) begin
      paralle_data <= fifo_q.pop_front();
      rd_pulses    <= rd_pulses + 1;
    end
  end

  // Request / empty driver, updated shortly after each rising edge.
  initial begin : drive_req
    forever begin
      @(posedge sysclk_12);
      #2;
      if (fifo_mode) begin
        uart_en = (fifo_q.size() != 0) && (send_sta_flg !== 1'b1);
        rdempty = (fifo_q.size() == 0);
      end else begin
        uart_en = man_en;
        rdempty = man_empty;
      end
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  // Line level during each bit period of a frame carrying byte b.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = ((b >> i) & 8'd1) != 8'd0;
    if (NB == 11) f[9] = ($countones(b) % 2) == 1;
    return f;
  endfunction

  task automatic frame_check();
    logic [7:0]  b;
    logic [10:0] f;
    int          bad;
    int          busy_n;
    if (last_end >= 0) last_gap = cyc - last_end;
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 1, 0);
      return;
    end
    b      = exp_q.pop_front();
    f      = frame_bits(b);
    busy_n = 1;
    check("load_cycle_line_high", tx_data, 1);
    for (int i = 0; i < NB; i++) begin
      bad = 0;
      for (int j = 0; j < B; j++) begin
        @(negedge sysclk_12);
        if (tx_data !== f[i]) bad++;
        if (send_sta_flg === 1'b1) busy_n++;
      end
      check($sformatf("frame_%02h_bit%0d_bad_samples", b, i), bad, 0);
    end
    @(negedge sysclk_12);
    check($sformatf("frame_%02h_busy_len", b), busy_n, 1 + NB * B);
    check("busy_drop", send_sta_flg, 0);
    check("idle_after_stop", tx_data, 1);
    last_end = cyc;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic busy_q;
    busy_q = 1'b0;
    forever begin
      @(negedge sysclk_12);
      if (mon_en && send_sta_flg === 1'b1 && !busy_q) begin
        mon_busy = 1'b1;
        frame_check();
        mon_busy = 1'b0;
      end
      busy_q = (send_sta_flg === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || mon_busy || send_sta_flg === 1'b1)
           && n < 20000) begin
      @(negedge sysclk_12);
      n++;
    end
    check($sformatf("%s_completes_in_time", name), n < 20000, 1);
    repeat (2) @(negedge sysclk_12);
  endtask

  task automatic manual_send(input logic [7:0] b);
    int n;
    man_data  = b;
    man_empty = 1'b0;
    exp_q.push_back(b);
    repeat (2) @(negedge sysclk_12);
    man_en = 1'b1;
    n = 0;
    while (uart_en !== 1'b1 && n < 10) begin
      @(negedge sysclk_12);
      n++;
    end
    check("busy_before_start_edge", send_sta_flg, 0);
    @(negedge sysclk_12);
    check("busy_after_one_edge", send_sta_flg, 1);
    man_en = 1'b0;
    wait_idle($sformatf("manual_%02h", b));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int rd0;
    int n;
    int bad_busy;
    int bad_line;
    logic [7:0] rb;

    // Reset held over several clocks with the request toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge sysclk_12);
      if (i > 0) begin
        check("rst_hold_tx", tx_data, 1);
        check("rst_hold_busy", send_sta_flg, 0);
      end
      man_en = (i % 2 == 0);
    end
    @(negedge sysclk_12);
    i_rest = 1'b0;
    repeat (3) @(negedge sysclk_12);
    check("post_rst_tx", tx_data, 1);
    check("post_rst_busy", send_sta_flg, 0);

    // Single frame with latency check.
    manual_send(8'hA5);

    // Request edge while FIFO empty: no frame.
    man_empty = 1'b1;
    repeat (3) @(negedge sysclk_12);
    man_en = 1'b1;
    bad_busy = 0;
    bad_line = 0;
    repeat (30) begin
      @(negedge sysclk_12);
      if (send_sta_flg !== 1'b0) bad_busy++;
      if (tx_data !== 1'b1) bad_line++;
    end
    check("empty_req_busy_samples", bad_busy, 0);
    check("empty_req_line_low_samples", bad_line, 0);
    man_en = 1'b0;
    repeat (3) @(negedge sysclk_12);
    man_empty = 1'b0;
    repeat (3) @(negedge sysclk_12);

    // Back-to-back frames from the FIFO.
    fifo_mode = 1'b1;
    repeat (3) @(negedge sysclk_12);
    rd0 = rd_pulses;
    fifo_q.push_back(8'h00); exp_q.push_back(8'h00);
    fifo_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    wait_idle("b2b");
    check("b2b_read_cycles", rd_pulses - rd0, 2);
    check("b2b_busy_low_gap", last_gap, 1);

    // Parity-sensitive bytes, then randomized traffic.
    rd0 = rd_pulses;
    fifo_q.push_back(8'h07); exp_q.push_back(8'h07);
    repeat ($urandom_range(0, 300)) @(negedge sysclk_12);
    fifo_q.push_back(8'h03); exp_q.push_back(8'h03);
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 1200)) @(negedge sysclk_12);
      rb = 8'($urandom_range(0, 255));
      fifo_q.push_back(rb);
      exp_q.push_back(rb);
    end
    wait_idle("random");
    check("random_read_cycles", rd_pulses - rd0, 8);

    // Reset in the middle of data bit 3 aborts the frame.
    fifo_mode = 1'b0;
    mon_en    = 1'b0;
    man_data  = 8'h52;
    man_empty = 1'b0;
    repeat (3) @(negedge sysclk_12);
    man_en = 1'b1;
    n = 0;
    while (send_sta_flg !== 1'b1 && n < 10) begin
      @(negedge sysclk_12);
      n++;
    end
    check("abort_frame_started", send_sta_flg, 1);
    man_en = 1'b0;
    repeat (1 + 4 * B + B / 2) @(negedge sysclk_12);
    check("abort_mid_data_bit3", tx_data, 0);
    i_rest = 1'b1;
    @(negedge sysclk_12);
    check("abort_tx_high", tx_data, 1);
    check("abort_busy_low", send_sta_flg, 0);
    i_rest = 1'b0;
    repeat (3) @(negedge sysclk_12);
    mon_en = 1'b1;
    manual_send(8'hC3);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #(800_000);
    checks++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
